// File: rtl/ffnn_pkg.sv
// Shared types and defaults for the FFNN argmax output stage.
// Defaults match the iris classifier (3 classes, 64-bit signed scores).
// The top module re-derives widths from its own parameters; these are the defaults.
package ffnn_pkg;

  localparam int DEF_SIZE        = 64;
  localparam int DEF_NUM_CLASSES = 3;
  localparam int DEF_CLS_W       = $clog2(DEF_NUM_CLASSES);

  typedef logic signed [DEF_SIZE-1:0] score_t;
  typedef logic [DEF_CLS_W-1:0]       cls_t;

  // ACCUM: collecting score beats; HOLD: result presented on the output
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/ffnn_max_cmp.sv
// Signed compare-and-select: keeps the running best or takes the incoming beat.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result with its own handshake.
module ffnn_max_cmp #(
  parameter int SIZE  = ffnn_pkg::DEF_SIZE,
  parameter int CLS_W = ffnn_pkg::DEF_CLS_W
) (
  input  logic                   first_i,       // first beat always wins
  input  logic signed [SIZE-1:0] best_score_i,
  input  logic [CLS_W-1:0]       best_idx_i,
  input  logic signed [SIZE-1:0] cand_score_i,
  input  logic [CLS_W-1:0]       cand_idx_i,
  output logic                   win_o,
  output logic [CLS_W-1:0]       idx_o,
  output logic signed [SIZE-1:0] score_o
);

  // Strictly greater, so ties keep the earlier (lower) index
  always_comb begin
    win_o   = first_i || ($signed(cand_score_i) > $signed(best_score_i));
    idx_o   = win_o ? cand_idx_i   : best_idx_i;
    score_o = win_o ? cand_score_i : best_score_i;
  end

endmodule

// File: rtl/ffnn_argmax_seq.sv
// Sequential argmax over per-class scores, one beat per cycle; one result per inference.
// Latency: result valid 1 cycle after the final beat is accepted.
// Backpressure: in_ready = !out_valid || out_ready; result held stable until accepted.
module ffnn_argmax_seq #(
  parameter  int SIZE        = ffnn_pkg::DEF_SIZE,
  parameter  int NUM_CLASSES = ffnn_pkg::DEF_NUM_CLASSES,
  localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [SIZE-1:0] in_score_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CLS_W-1:0]       out_class_o,
  output logic signed [SIZE-1:0] out_score_o,
  output logic                   err_sticky_o
);

  import ffnn_pkg::*;

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  state_e                 state_q, state_d;
  logic [CLS_W-1:0]       cnt_q, cnt_d;
  logic [CLS_W-1:0]       best_idx_q, best_idx_d;
  logic signed [SIZE-1:0] best_score_q, best_score_d;
  logic [CLS_W-1:0]       out_class_q, out_class_d;
  logic signed [SIZE-1:0] out_score_q, out_score_d;
  logic                   err_q, err_d;

  logic                   beat_fire;
  logic                   out_fire;
  logic                   is_final;
  logic                   done;
  logic                   cmp_win;
  logic [CLS_W-1:0]       cmp_idx;
  logic signed [SIZE-1:0] cmp_score;

  assign is_final  = (cnt_q == LAST_IDX);
  assign beat_fire = in_valid_i && in_ready_o;
  assign out_fire  = out_valid_o && out_ready_i;
  // An early in_last truncates the inference, so it completes like a final beat
  assign done      = beat_fire && (is_final || in_last_i);

  ffnn_max_cmp #(
    .SIZE  (SIZE),
    .CLS_W (CLS_W)
  ) u_cmp (
    .first_i      (cnt_q == '0),
    .best_score_i (best_score_q),
    .best_idx_i   (best_idx_q),
    .cand_score_i (in_score_i),
    .cand_idx_i   (cnt_q),
    .win_o        (cmp_win),
    .idx_o        (cmp_idx),
    .score_o      (cmp_score)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: completing an inference wins over draining the previous result
  always_comb begin
    state_d = state_q;
    if (done) begin
      state_d = HOLD;
    end else if (out_fire) begin
      state_d = ACCUM;
    end
  end

  // FSM outputs; in_ready depends only on out_valid and out_ready
  always_comb begin
    out_valid_o = (state_q == HOLD);
    in_ready_o  = (state_q != HOLD) || out_ready_i;
  end

  // Datapath next state: counter, running best, result capture, error flag
  always_comb begin
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    err_d        = err_q;
    if (beat_fire) begin
      if (in_last_i != is_final) begin
        err_d = 1'b1;
      end
      if (done) begin
        cnt_d       = '0;
        out_class_d = cmp_idx;
        out_score_d = cmp_score;
      end else begin
        cnt_d = cnt_q + CLS_W'(1);
        if (cmp_win) begin
          best_idx_d   = cnt_q;
          best_score_d = in_score_i;
        end
      end
    end
  end

  // Datapath registers; reset discards any partial inference
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      out_class_q  <= '0;
      out_score_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      err_q        <= err_d;
    end
  end

  assign out_class_o  = out_class_q;
  assign out_score_o  = out_score_q;
  assign err_sticky_o = err_q;

endmodule
